// File: rtl/kw_fifo_ctrl_1ra_1ws.sv
// -----------------------------------------------------------------------------
// kw_fifo_ctrl_1ra_1ws
//
// FIFO controller that drives an external RAM. The RAM has one asynchronous
// read port and one synchronous write port. The block holds only the read
// pointer, the write pointer, the occupancy count and two sticky error flags.
// Payload storage lives in the attached RAM. The head entry is read
// combinationally through ram_rd_addr/ram_data_out, so out_data has no
// output register. The write-to-read latency is one cycle.
//
// Ports
//   clock, reset       sole clock; asynchronous active-high reset
//   flush              synchronous clear of all entries (beats push/pop)
//   in_valid/in_ready  push handshake; in_data is the push payload
//   out_valid/out_ready pop handshake; out_data is the head entry payload
//   ram_cs_n, ram_we_n active-low RAM select/write, both equal to !push
//   ram_wr_addr        write pointer; ram_data_in mirrors in_data
//   ram_rd_addr        read pointer; ram_data_out returns the head entry
//   count              occupancy, 0..DEPTH
//   full/empty/almost_full  decoded from the registered count
//   overflow/underflow sticky error flags, cleared by reset or flush
// -----------------------------------------------------------------------------
module kw_fifo_ctrl_1ra_1ws #(
    parameter int DATA_WIDTH = 256,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int AF_LEVEL   = DEPTH - 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  ram_cs_n,
    output logic                  ram_we_n,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    input  logic [DATA_WIDTH-1:0] ram_data_out,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  overflow,
    output logic                  underflow
);

    // DEPTH does not have to be a power of two, so the pointers wrap explicitly.
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AF_CNT    = (ADDR_WIDTH + 1)'(AF_LEVEL);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  push;
    logic                  pop;

    // The status flags come only from the registered count. Because of this,
    // the handshake outputs never depend combinationally on in_valid or out_ready.
    assign full        = (count_q == DEPTH_CNT);
    assign empty       = (count_q == '0);
    assign almost_full = (count_q >= AF_CNT);

    assign in_ready  = !full && !flush;
    assign out_valid = !empty;

    // in_ready stays high while reset is asserted because the count is zero.
    // For that reason, push is also gated by reset, so no RAM write can be
    // issued during reset.
    assign push = in_valid && in_ready && !reset;
    assign pop  = out_valid && out_ready;

    assign ram_cs_n    = !push;
    assign ram_we_n    = !push;
    assign ram_wr_addr = wr_ptr_q;
    assign ram_data_in = in_data;
    assign ram_rd_addr = rd_ptr_q;
    assign out_data    = ram_data_out;

    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    always_comb begin
        // NOTE: every _d starts from its _q value, so no path leaves a signal
        // unassigned and no latch is inferred.
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q | (in_valid & full);
        underflow_d = underflow_q | (out_ready & empty);

        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == LAST_ADDR) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let all flops update together at
            // the edge, whatever order the statements appear in.
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: tb/tb_kw_fifo_ctrl_1ra_1ws.sv
// -----------------------------------------------------------------------------
// Bench for kw_fifo_ctrl_1ra_1ws. Instance A has DEPTH=32 and instance B has
// DEPTH=5. Both use 8-bit payloads. Each instance is attached to a small
// behavioural RAM with asynchronous read and synchronous write. Inputs change
// 1 ns after a rising edge. Outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_kw_fifo_ctrl_1ra_1ws;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- instance A: DEPTH 32 ----------------
    logic       a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [7:0] a_in_data, a_out_data, a_ram_data_in, a_ram_data_out;
    logic       a_cs_n, a_we_n, a_full, a_empty, a_af, a_ovf, a_unf;
    logic [4:0] a_wr_addr, a_rd_addr;
    logic [5:0] a_count;
    logic [7:0] mem_a [32];
    int         a_wr_cnt = 0;

    kw_fifo_ctrl_1ra_1ws #(.DATA_WIDTH(8), .DEPTH(32)) u_a (
        .clock(clock), .reset(reset), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .ram_cs_n(a_cs_n), .ram_we_n(a_we_n),
        .ram_wr_addr(a_wr_addr), .ram_rd_addr(a_rd_addr),
        .ram_data_in(a_ram_data_in), .ram_data_out(a_ram_data_out),
        .count(a_count), .full(a_full), .empty(a_empty), .almost_full(a_af),
        .overflow(a_ovf), .underflow(a_unf)
    );

    always @(posedge clock) begin
        if (!a_cs_n && !a_we_n) begin
            mem_a[a_wr_addr] <= a_ram_data_in;
            a_wr_cnt <= a_wr_cnt + 1;
        end
    end
    assign a_ram_data_out = mem_a[a_rd_addr];

    // ---------------- instance B: DEPTH 5 ----------------
    logic       b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [7:0] b_in_data, b_out_data, b_ram_data_in, b_ram_data_out;
    logic       b_cs_n, b_we_n, b_full, b_empty, b_af, b_ovf, b_unf;
    logic [2:0] b_wr_addr, b_rd_addr;
    logic [3:0] b_count;
    logic [7:0] mem_b [8];

    kw_fifo_ctrl_1ra_1ws #(.DATA_WIDTH(8), .DEPTH(5)) u_b (
        .clock(clock), .reset(reset), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .ram_cs_n(b_cs_n), .ram_we_n(b_we_n),
        .ram_wr_addr(b_wr_addr), .ram_rd_addr(b_rd_addr),
        .ram_data_in(b_ram_data_in), .ram_data_out(b_ram_data_out),
        .count(b_count), .full(b_full), .empty(b_empty), .almost_full(b_af),
        .overflow(b_ovf), .underflow(b_unf)
    );

    always @(posedge clock) begin
        if (!b_cs_n && !b_we_n) mem_b[b_wr_addr] <= b_ram_data_in;
    end
    assign b_ram_data_out = mem_b[b_rd_addr];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Stimulus only: push n entries base, base+1, ... into A with out_ready=0.
    task automatic push_a(input int n, input logic [7:0] base);
        a_out_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = 8'(base + i);
            tick();
        end
        a_in_valid = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        a_in_valid = 1'b1;  // must be ignored while reset is asserted
        a_in_data  = 8'hEE;
        #2;
        n_cmp++; if (a_count !== 6'd0)  begin n_err++; $display("FAIL reset_count: got %0d want 0", a_count); end
        n_cmp++; if (a_empty !== 1'b1)  begin n_err++; $display("FAIL reset_empty: got %b want 1", a_empty); end
        n_cmp++; if (a_full !== 1'b0)   begin n_err++; $display("FAIL reset_full: got %b want 0", a_full); end
        n_cmp++; if (a_af !== 1'b0)     begin n_err++; $display("FAIL reset_af: got %b want 0", a_af); end
        n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid); end
        n_cmp++; if (a_in_ready !== 1'b1)  begin n_err++; $display("FAIL reset_in_ready: got %b want 1", a_in_ready); end
        n_cmp++; if (a_cs_n !== 1'b1 || a_we_n !== 1'b1) begin n_err++; $display("FAIL reset_ram_ctl: got cs_n=%b we_n=%b want 1/1", a_cs_n, a_we_n); end
        n_cmp++; if (a_ovf !== 1'b0 || a_unf !== 1'b0) begin n_err++; $display("FAIL reset_flags: got ovf=%b unf=%b want 0/0", a_ovf, a_unf); end
        tick();
        n_cmp++; if (a_wr_cnt !== 0) begin n_err++; $display("FAIL reset_no_write: got %0d writes want 0", a_wr_cnt); end
        a_in_valid = 1'b0;
        reset = 1'b0;
        tick();
        n_cmp++; if (b_empty !== 1'b1 || b_count !== 4'd0) begin n_err++; $display("FAIL reset_b: got empty=%b count=%0d want 1/0", b_empty, b_count); end
    endtask

    task automatic test_fill_drain();
        a_out_ready = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = 8'(i);
            #1;
            n_cmp++; if (a_in_ready !== 1'b1 || a_we_n !== 1'b0) begin n_err++; $display("FAIL fill_accept[%0d]: got rdy=%b we_n=%b want 1/0", i, a_in_ready, a_we_n); end
            tick();
            n_cmp++; if (a_count !== 6'(i)) begin n_err++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, a_count, i); end
            if (i == 29) begin
                n_cmp++; if (a_af !== 1'b0) begin n_err++; $display("FAIL af_below: got %b want 0", a_af); end
            end
            if (i == 30) begin
                n_cmp++; if (a_af !== 1'b1) begin n_err++; $display("FAIL af_at: got %b want 1", a_af); end
            end
        end
        a_in_valid = 1'b0;
        n_cmp++; if (a_full !== 1'b1)     begin n_err++; $display("FAIL fill_full: got %b want 1", a_full); end
        n_cmp++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL fill_in_ready: got %b want 0", a_in_ready); end
        a_out_ready = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            #1;
            n_cmp++; if (a_out_valid !== 1'b1 || a_out_data !== 8'(i)) begin n_err++; $display("FAIL drain[%0d]: got v=%b d=%0h want 1/%0h", i, a_out_valid, a_out_data, i); end
            tick();
        end
        a_out_ready = 1'b0;
        n_cmp++; if (a_empty !== 1'b1 || a_count !== 6'd0) begin n_err++; $display("FAIL drain_empty: got empty=%b count=%0d want 1/0", a_empty, a_count); end
        n_cmp++; if (a_unf !== 1'b0) begin n_err++; $display("FAIL drain_no_underflow: got %b want 0", a_unf); end
    endtask

    task automatic test_simul_push_pop();
        // Both pointers wrapped to 0 after 32 pushes and 32 pops.
        push_a(3, 8'h11);
        a_in_valid = 1'b1; a_in_data = 8'h14; a_out_ready = 1'b1;
        #1;
        n_cmp++; if (a_wr_addr !== 5'd3 || a_rd_addr !== 5'd0) begin n_err++; $display("FAIL pp_addr_pre: got wr=%0d rd=%0d want 3/0", a_wr_addr, a_rd_addr); end
        n_cmp++; if (a_out_data !== 8'h11 || a_we_n !== 1'b0) begin n_err++; $display("FAIL pp_data_pre: got d=%0h we_n=%b want 11/0", a_out_data, a_we_n); end
        tick();
        n_cmp++; if (a_count !== 6'd3) begin n_err++; $display("FAIL pp_count: got %0d want 3", a_count); end
        n_cmp++; if (a_wr_addr !== 5'd4 || a_rd_addr !== 5'd1) begin n_err++; $display("FAIL pp_addr_post: got wr=%0d rd=%0d want 4/1", a_wr_addr, a_rd_addr); end
        n_cmp++; if (a_out_data !== 8'h12) begin n_err++; $display("FAIL pp_head: got %0h want 12", a_out_data); end
        push_a(29, 8'h20);
        n_cmp++; if (a_full !== 1'b1) begin n_err++; $display("FAIL pp_full: got %b want 1", a_full); end
        a_in_valid = 1'b1; a_in_data = 8'h99; a_out_ready = 1'b1;
        #1;
        n_cmp++; if (a_in_ready !== 1'b0 || a_we_n !== 1'b1) begin n_err++; $display("FAIL ppfull_block: got rdy=%b we_n=%b want 0/1", a_in_ready, a_we_n); end
        tick();
        n_cmp++; if (a_count !== 6'd31 || a_rd_addr !== 5'd2) begin n_err++; $display("FAIL ppfull_pop: got count=%0d rd=%0d want 31/2", a_count, a_rd_addr); end
        n_cmp++; if (a_ovf !== 1'b1) begin n_err++; $display("FAIL ppfull_ovf: got %b want 1", a_ovf); end
        a_in_valid = 1'b0; a_out_ready = 1'b0;
        a_flush = 1'b1; tick(); a_flush = 1'b0;
        n_cmp++; if (a_count !== 6'd0 || a_ovf !== 1'b0) begin n_err++; $display("FAIL pp_flush: got count=%0d ovf=%b want 0/0", a_count, a_ovf); end
    endtask

    task automatic test_flags();
        int wr_snap;
        a_out_ready = 1'b1;
        #1;
        n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL unf_out_valid: got %b want 0", a_out_valid); end
        tick();
        a_out_ready = 1'b0;
        n_cmp++; if (a_unf !== 1'b1) begin n_err++; $display("FAIL unf_set: got %b want 1", a_unf); end
        n_cmp++; if (a_count !== 6'd0 || a_rd_addr !== 5'd0) begin n_err++; $display("FAIL unf_hold: got count=%0d rd=%0d want 0/0", a_count, a_rd_addr); end
        push_a(32, 8'h80);
        wr_snap = a_wr_cnt;
        a_in_valid = 1'b1; a_in_data = 8'h55;
        #1;
        n_cmp++; if (a_we_n !== 1'b1) begin n_err++; $display("FAIL ovf_we_n: got %b want 1", a_we_n); end
        tick();
        a_in_valid = 1'b0;
        n_cmp++; if (a_ovf !== 1'b1 || a_count !== 6'd32) begin n_err++; $display("FAIL ovf_set: got ovf=%b count=%0d want 1/32", a_ovf, a_count); end
        n_cmp++; if (a_wr_cnt !== wr_snap) begin n_err++; $display("FAIL ovf_no_write: got %0d writes want %0d", a_wr_cnt, wr_snap); end
        n_cmp++; if (a_unf !== 1'b1) begin n_err++; $display("FAIL unf_sticky: got %b want 1", a_unf); end
        a_flush = 1'b1; a_in_valid = 1'b1; a_out_ready = 1'b1;
        #1;
        n_cmp++; if (a_in_ready !== 1'b0 || a_we_n !== 1'b1) begin n_err++; $display("FAIL flush_block: got rdy=%b we_n=%b want 0/1", a_in_ready, a_we_n); end
        tick();
        a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
        n_cmp++; if (a_count !== 6'd0 || a_empty !== 1'b1) begin n_err++; $display("FAIL flush_count: got count=%0d empty=%b want 0/1", a_count, a_empty); end
        n_cmp++; if (a_ovf !== 1'b0 || a_unf !== 1'b0) begin n_err++; $display("FAIL flush_flags: got ovf=%b unf=%b want 0/0", a_ovf, a_unf); end
        n_cmp++; if (a_wr_addr !== 5'd0 || a_rd_addr !== 5'd0) begin n_err++; $display("FAIL flush_ptrs: got wr=%0d rd=%0d want 0/0", a_wr_addr, a_rd_addr); end
        // A flush that is not at full must still block a push.
        push_a(2, 8'h01);
        a_flush = 1'b1; a_in_valid = 1'b1;
        #1;
        n_cmp++; if (a_in_ready !== 1'b0 || a_we_n !== 1'b1) begin n_err++; $display("FAIL flush_mid_block: got rdy=%b we_n=%b want 0/1", a_in_ready, a_we_n); end
        tick();
        a_flush = 1'b0; a_in_valid = 1'b0;
        n_cmp++; if (a_count !== 6'd0) begin n_err++; $display("FAIL flush_mid_count: got %0d want 0", a_count); end
    endtask

    task automatic test_reset_mid();
        push_a(7, 8'h30);
        n_cmp++; if (a_count !== 6'd7) begin n_err++; $display("FAIL rmid_pre: got %0d want 7", a_count); end
        #2;
        reset = 1'b1; a_in_valid = 1'b1; a_in_data = 8'h77;
        #1;
        n_cmp++; if (a_count !== 6'd0 || a_empty !== 1'b1) begin n_err++; $display("FAIL rmid_async: got count=%0d empty=%b want 0/1", a_count, a_empty); end
        n_cmp++; if (a_we_n !== 1'b1) begin n_err++; $display("FAIL rmid_we_n: got %b want 1", a_we_n); end
        tick();
        reset = 1'b0; a_in_valid = 1'b0;
        tick();
        a_in_valid = 1'b1; a_in_data = 8'hAB;
        #1;
        n_cmp++; if (a_wr_addr !== 5'd0 || a_we_n !== 1'b0) begin n_err++; $display("FAIL rmid_push: got wr=%0d we_n=%b want 0/0", a_wr_addr, a_we_n); end
        n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_no_bypass: got %b want 0", a_out_valid); end
        tick();
        a_in_valid = 1'b0;
        n_cmp++; if (a_out_valid !== 1'b1 || a_out_data !== 8'hAB) begin n_err++; $display("FAIL rmid_read: got v=%b d=%0h want 1/ab", a_out_valid, a_out_data); end
    endtask

    task automatic test_wrap();
        logic [7:0] q [$];
        int k = 0;
        int cyc = 0;
        logic do_push, do_pop;
        while (!(k == 12 && q.size() == 0) && cyc < 100) begin
            do_push     = (k < 12) && (q.size() < 5);
            b_in_valid  = do_push;
            b_in_data   = 8'(8'h40 + k);
            b_out_ready = (cyc % 3 == 2) || (k >= 12);
            do_pop      = b_out_ready && (q.size() > 0);
            #1;
            n_cmp++; if (b_count !== 4'(q.size()) || b_count > 4'd5) begin n_err++; $display("FAIL wrap_count[%0d]: got %0d want %0d", cyc, b_count, q.size()); end
            if (do_push) begin
                n_cmp++; if (b_wr_addr !== 3'(k % 5) || b_we_n !== 1'b0) begin n_err++; $display("FAIL wrap_wr_addr[%0d]: got %0d we_n=%b want %0d/0", k, b_wr_addr, b_we_n, k % 5); end
            end
            if (do_pop) begin
                n_cmp++; if (b_out_valid !== 1'b1 || b_out_data !== q[0]) begin n_err++; $display("FAIL wrap_order[%0d]: got v=%b d=%0h want 1/%0h", cyc, b_out_valid, b_out_data, q[0]); end
            end
            tick();
            if (do_pop) void'(q.pop_front());
            if (do_push) begin q.push_back(8'(8'h40 + k)); k++; end
            cyc++;
        end
        b_in_valid = 1'b0; b_out_ready = 1'b0;
        n_cmp++; if (cyc >= 100) begin n_err++; $display("FAIL wrap_timeout: got %0d cycles want < 100", cyc); end
        n_cmp++; if (b_empty !== 1'b1 || b_unf !== 1'b0 || b_ovf !== 1'b0) begin n_err++; $display("FAIL wrap_end: got empty=%b unf=%b ovf=%b want 1/0/0", b_empty, b_unf, b_ovf); end
    endtask

    initial begin
        reset = 1'b1;
        a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_data = '0;
        b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = '0;
        test_reset();
        test_fill_drain();
        test_simul_push_pop();
        test_flags();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/kw_fifo_ctrl_1ra_1ws.md
KW_FIFO_CTRL_1RA_1WS -- requirements
Module: KW_fifo_ctrl_1ra_1ws

Interface
REQ-001 The block SHALL have the parameter DATA_WIDTH, default 256, giving the payload width in bits.
REQ-002 The block SHALL have the parameter DEPTH, default 32, giving the entry count of the attached RAM; any value >= 2 is legal, not only powers of two.
REQ-003 The block SHALL have the parameter ADDR_WIDTH, default $clog2(DEPTH), giving the RAM address width.
REQ-004 The block SHALL have the parameter AF_LEVEL, default DEPTH-2, giving the almost_full threshold.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset, in the following port order:
- clock  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of all entries.
- in_valid  in  1  push request.
- in_ready  out  1  push may be accepted.
- in_data  in  DATA_WIDTH  push payload.
- out_valid  out  1  head entry is available.
- out_ready  in  1  consumer takes the head entry.
- out_data  out  DATA_WIDTH  head entry payload.
- ram_cs_n  out  1  RAM chip select, active-low.
- ram_we_n  out  1  RAM write enable, active-low.
- ram_wr_addr  out  ADDR_WIDTH  RAM write address.
- ram_rd_addr  out  ADDR_WIDTH  RAM asynchronous read address.
- ram_data_in  out  DATA_WIDTH  RAM write data.
- ram_data_out  in  DATA_WIDTH  RAM asynchronous read data.
- count  out  ADDR_WIDTH+1  current occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- overflow  out  1  sticky: push attempted while full.
- underflow  out  1  sticky: pop attempted while empty.

Function
REQ-006 The block SHALL drive the write side of a 1-async-read / 1-sync-write RAM: a RAM write commits at the clock edge on which ram_cs_n=0 and ram_we_n=0.
REQ-007 The block SHALL define push = in_valid & in_ready and pop = out_valid & out_ready.
REQ-008 The block SHALL drive in_ready = !full and out_valid = !empty; neither output SHALL depend combinationally on in_valid or out_ready.
REQ-009 The block SHALL drive ram_cs_n = ram_we_n = !push combinationally.
REQ-010 The block SHALL drive ram_wr_addr = wr_ptr and ram_data_in = in_data.
REQ-011 The block SHALL drive ram_rd_addr = rd_ptr and out_data = ram_data_out combinationally, with no output register.
REQ-012 On push, the block SHALL advance wr_ptr by 1, wrapping from DEPTH-1 to 0.
REQ-013 On pop, the block SHALL advance rd_ptr by 1, wrapping from DEPTH-1 to 0.
REQ-014 The block SHALL update count as:
- push only: +1.
- pop only: -1.
- push and pop in the same cycle: unchanged, with both pointers advancing.
REQ-015 Write-to-read latency SHALL be 1 cycle: data pushed into an empty FIFO at edge N SHALL have out_valid=1 in the cycle following edge N; there is no same-cycle bypass.
REQ-016 When full, in_ready SHALL be 0 even if out_ready=1 in that cycle; no write SHALL reach the RAM.
REQ-017 When empty, pop SHALL be impossible; rd_ptr and count SHALL hold.
REQ-018 in_valid=1 while full SHALL set overflow; out_ready=1 while empty SHALL set underflow. Both flags SHALL clear only on reset or flush.
REQ-019 flush=1 at an edge SHALL zero wr_ptr, rd_ptr, count, overflow and underflow, taking priority over a simultaneous push or pop.
REQ-020 While flush=1, in_ready SHALL be forced to 0 so that no RAM write occurs in that cycle.
REQ-021 full, empty and almost_full SHALL be decoded from the registered count only.

Reset
REQ-022 While reset=1, the block SHALL asynchronously force wr_ptr=0, rd_ptr=0, count=0, overflow=0 and underflow=0.
REQ-023 The resulting output values SHALL be empty=1, full=0, almost_full=0, out_valid=0, in_ready=1, ram_cs_n=1 and ram_we_n=1.
REQ-024 in_valid SHALL be ignored while reset=1, so that no RAM write is issued during reset.
REQ-025 Reset asserted mid-traffic SHALL discard all entries; the first push after release SHALL be written to address 0.
REQ-026 RAM contents SHALL NOT be cleared by reset; stale data SHALL never be presented because out_valid=0 while empty.

Verification
REQ-027 Fill, then drain: push 0x01..0x20 with out_ready=0 -> full=1 after 32 pushes and in_ready=0; then out_ready=1 -> out_data sequence 0x01..0x20, then empty=1.
REQ-028 Wrap-around: DEPTH=5, 12 pushes interleaved with pops -> ram_wr_addr sequence 0,1,2,3,4,0,1,..., output order preserved, count never exceeds 5.
REQ-029 Simultaneous push and pop at count=3 -> count stays 3 and both addresses increment; simultaneous push and pop at count=DEPTH -> pop only, count becomes DEPTH-1.
REQ-030 Error flags: in_valid=1 while full -> overflow=1 and no RAM write; out_ready=1 while empty -> underflow=1; flush -> both clear and count=0.
REQ-031 Reset at count=7 -> count=0, empty=1 and ram_we_n=1 immediately, without waiting for a clock edge; after release, push 0xAB -> written to address 0 and out_data=0xAB one cycle later.
